// File: rtl/boundflasher_ctrl_pkg.sv
// Shared definitions for the bound flasher sequencer.
// Holds the sequencer state encoding, the lamp patterns that mark the
// direction-change and kick-back points, and the two one-lamp step helpers.
package boundflasher_ctrl_pkg;

    // The encoding is fixed so that hierarchical debug reads of 'state' are stable
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP15 = 3'd1,
        DN5  = 3'd2,
        UP10 = 3'd3,
        DN0  = 3'd4,
        UP5  = 3'd5,
        DN0B = 3'd6,
        KB0  = 3'd7
    } state_t;

    localparam logic [15:0] ALL_ON  = 16'hFFFF;
    localparam logic [15:0] B5_OFF  = 16'h001F;
    localparam logic [15:0] B5_ON   = 16'h003F;
    localparam logic [15:0] B10_ON  = 16'h07FF;
    localparam logic [15:0] ALL_OFF = 16'h0000;
    localparam logic [15:0] FIRST   = 16'h0001;

    // Lights one more lamp at the top of the contiguous run
    function automatic logic [15:0] step_on(input logic [15:0] lamps);
        return {lamps[14:0], 1'b1};
    endfunction

    // Turns off the highest lit lamp of the contiguous run
    function automatic logic [15:0] step_off(input logic [15:0] lamps);
        return {1'b0, lamps[15:1]};
    endfunction

endpackage

// File: rtl/boundflasher_ctrl_if.sv
// Lamp-bank bus of the bound flasher.
// flick : one-cycle start / kick-back request toward the sequencer
// led   : 16 lamp outputs from the sequencer, lit lamps contiguous from bit 0
// The master side drives requests and watches the lamps; the slave is the sequencer.
interface boundflasher_ctrl_if;
    logic        flick;
    logic [15:0] led;

    modport master (output flick, input led);
    modport slave  (input flick, output led);
endinterface

// File: rtl/boundflasher_ctrl.sv
// Bound flasher sequencer: a single flick starts a light run that bounces
// between lamp bounds 15, 5, 10, 0, 5, 0 and then goes idle. A flick at
// lamp 5 or lamp 10 on the first climb, or at lamp 10 on the second climb,
// kicks the run back down.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of boundflasher_ctrl_if (flick in, led out)
module boundflasher_ctrl
    import boundflasher_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    boundflasher_ctrl_if.slave        bus
);

    state_t      state;
    logic [15:0] led;

    assign bus.led = led;

    // Each edge either steps the lamp run in the current direction or, when
    // the run has reached the state's bound, switches state and immediately
    // applies the new direction's step so no cycle is spent sitting at a bound.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            led   <= ALL_OFF;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flick) begin
                        state <= UP15;
                        led   <= FIRST;
                    end
                end
                UP15: begin
                    if (bus.flick && (led == B5_ON || led == B10_ON)) begin
                        state <= KB0;
                        led   <= step_off(led);
                    end else if (led == ALL_ON) begin
                        state <= DN5;
                        led   <= step_off(led);
                    end else begin
                        led   <= step_on(led);
                    end
                end
                DN5: begin
                    if (led == B5_OFF) begin
                        state <= UP10;
                        led   <= step_on(led);
                    end else begin
                        led   <= step_off(led);
                    end
                end
                UP10: begin
                    // Both branches at lamp 10 step down; the kick-back only
                    // changes which bound the run heads for next.
                    if (led == B10_ON) begin
                        state <= bus.flick ? DN5 : DN0;
                        led   <= step_off(led);
                    end else begin
                        led   <= step_on(led);
                    end
                end
                DN0: begin
                    if (led == ALL_OFF) begin
                        state <= UP5;
                        led   <= step_on(led);
                    end else begin
                        led   <= step_off(led);
                    end
                end
                UP5: begin
                    if (led == B5_ON) begin
                        state <= DN0B;
                        led   <= step_off(led);
                    end else begin
                        led   <= step_on(led);
                    end
                end
                DN0B: begin
                    if (led == ALL_OFF) begin
                        state <= IDLE;
                    end else begin
                        led   <= step_off(led);
                    end
                end
                KB0: begin
                    if (led == ALL_OFF) begin
                        state <= UP15;
                        led   <= FIRST;
                    end else begin
                        led   <= step_off(led);
                    end
                end
                default: begin
                    state <= IDLE;
                    led   <= ALL_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boundflasher_ctrl.sv
// Self-checking bench for boundflasher_ctrl. A lamp-count model predicts
// state and lamps for every edge; predictions are queued as stimulus is
// driven and compared after the edge. Milestone lamp patterns of the plain
// run are also checked against fixed constants.
module tb_boundflasher_ctrl;
    import boundflasher_ctrl_pkg::*;

    logic clk;
    logic rst;

    boundflasher_ctrl_if bus ();

    boundflasher_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] led;
        logic [2:0]  st;
    } expect_t;

    expect_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Model: state plus number of lit lamps
    state_t mState = IDLE;
    int     mCount = 0;

    function automatic logic [15:0] countToLamps(input int n);
        logic [31:0] wide;
        wide = (32'd1 << n) - 32'd1;
        return wide[15:0];
    endfunction

    task automatic modelStep(input logic f, input logic r);
        if (r) begin
            mState = IDLE;
            mCount = 0;
        end else begin
            case (mState)
                IDLE: if (f) begin mState = UP15; mCount = 1; end
                UP15: begin
                    if (f && (mCount == 6 || mCount == 11)) begin mState = KB0; mCount--; end
                    else if (mCount == 16) begin mState = DN5; mCount = 15; end
                    else mCount++;
                end
                DN5:  if (mCount == 5) begin mState = UP10; mCount = 6; end else mCount--;
                UP10: begin
                    if (f && mCount == 11) begin mState = DN5; mCount = 10; end
                    else if (mCount == 11) begin mState = DN0; mCount = 10; end
                    else mCount++;
                end
                DN0:  if (mCount == 0) begin mState = UP5; mCount = 1; end else mCount--;
                UP5:  if (mCount == 6) begin mState = DN0B; mCount = 5; end else mCount++;
                DN0B: if (mCount == 0) mState = IDLE; else mCount--;
                KB0:  if (mCount == 0) begin mState = UP15; mCount = 1; end else mCount--;
                default: begin mState = IDLE; mCount = 0; end
            endcase
        end
    endtask

    // Compares the DUT against the oldest queued prediction
    task automatic checkOutput(input string tag);
        expect_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s: scoreboard empty", tag);
        end else begin
            e = expQ.pop_front();
            assert (bus.led === e.led && dut.state === e.st)
            else begin
                errors++;
                $error("[TB] FAIL %s: led=%h state=%0d, expected led=%h state=%0d",
                       tag, bus.led, dut.state, e.led, e.st);
            end
        end
    endtask

    // Drives one edge of inputs, queues the model prediction, checks after the edge
    task automatic applyStimulus(input logic f, input logic r, input string tag);
        expect_t e;
        bus.flick = f;
        rst       = r;
        modelStep(f, r);
        e.led = countToLamps(mCount);
        e.st  = 3'(mState);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkConst(input string tag, input logic [15:0] expLed, input logic [2:0] expSt);
        checks++;
        assert (bus.led === expLed && dut.state === expSt)
        else begin
            errors++;
            $error("[TB] FAIL %s: led=%h state=%0d, expected led=%h state=%0d",
                   tag, bus.led, dut.state, expLed, expSt);
        end
    endtask

    task automatic runToIdle(input int bound, input string tag);
        int k = 0;
        while (mState != IDLE && k < bound) begin
            applyStimulus(1'b0, 1'b0, tag);
            k++;
        end
        checkConst({tag, "_idle"}, ALL_OFF, 3'(IDLE));
    endtask

    initial begin
        bus.flick = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        // Reset and flick ignored under reset
        applyStimulus(1'b0, 1'b1, "reset0");
        applyStimulus(1'b0, 1'b1, "reset1");
        checkConst("reset_const", ALL_OFF, 3'(IDLE));
        applyStimulus(1'b1, 1'b1, "flick_in_reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "idle");

        // Reset in the middle of the second climb
        applyStimulus(1'b1, 1'b0, "mid_start");
        for (int i = 0; i < 29; i++) applyStimulus(1'b0, 1'b0, "mid_run");
        checkConst("mid_in_up10", 16'h00FF, 3'(UP10));
        applyStimulus(1'b0, 1'b1, "mid_reset");
        checkConst("mid_reset_const", ALL_OFF, 3'(IDLE));

        // Plain run with fixed milestones
        applyStimulus(1'b1, 1'b0, "full_e0");
        checkConst("full_e0_const", 16'h0001, 3'(UP15));
        for (int e = 1; e <= 56; e++) begin
            applyStimulus(1'b0, 1'b0, "full_run");
            case (e)
                15: checkConst("full_e15", 16'hFFFF, 3'(UP15));
                26: checkConst("full_e26", 16'h001F, 3'(DN5));
                32: checkConst("full_e32", 16'h07FF, 3'(UP10));
                43: checkConst("full_e43", 16'h0000, 3'(DN0));
                49: checkConst("full_e49", 16'h003F, 3'(UP5));
                55: checkConst("full_e55", 16'h0000, 3'(DN0B));
                56: checkConst("full_e56", 16'h0000, 3'(IDLE));
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, "after_full");

        // Kick-back at lamp 5 of the first climb
        applyStimulus(1'b1, 1'b0, "kb1_start");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, "kb1_climb");
        applyStimulus(1'b1, 1'b0, "kb1_kick");
        checkConst("kb1_const", 16'h001F, 3'(KB0));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, "kb1_down");
        checkConst("kb1_restart", 16'h0001, 3'(UP15));
        runToIdle(100, "kb1");

        // Kick-back at lamp 10 of the first climb
        applyStimulus(1'b1, 1'b0, "kb2_start");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, "kb2_climb");
        applyStimulus(1'b1, 1'b0, "kb2_kick");
        checkConst("kb2_const", 16'h03FF, 3'(KB0));
        runToIdle(100, "kb2");

        // Kick-back at lamp 10 of the second climb
        applyStimulus(1'b1, 1'b0, "kb3_start");
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, "kb3_climb");
        applyStimulus(1'b1, 1'b0, "kb3_kick");
        checkConst("kb3_const", 16'h03FF, 3'(DN5));
        runToIdle(100, "kb3");

        // Flick held at every non-kick point: same 56-edge trajectory
        applyStimulus(1'b1, 1'b0, "nk_start");
        for (int e = 1; e <= 56; e++) begin
            logic f;
            f = !((mState == UP15 && (mCount == 6 || mCount == 11)) ||
                  (mState == UP10 && mCount == 11));
            applyStimulus(f, 1'b0, "nk_run");
            if (e == 49) checkConst("nk_e49", 16'h003F, 3'(UP5));
        end
        checkConst("nk_e56", ALL_OFF, 3'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
